// File: rtl/fp_flag_latch.sv
// fp_flag_latch: turns per-result floating-point exception flags into a stable
// 4-bit LED vector.
//
// In stretch mode each flagged result lights its bits for STRETCH_CYCLES cycles.
// A new event restarts that window. In sticky mode the bits stay lit until the
// operator presses the clear button. The button is synchronized and debounced.
// A saturating counter records how many flagged results have been seen.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   flag_valid one-cycle strobe qualifying flag_in
//   flag_in    [3] invalid, [2] div-by-zero, [1] underflow, [0] overflow
//   sticky_en  1 = sticky mode, 0 = stretch mode
//   clr_btn    raw bouncing push-button, high = pressed
//   overfloat  registered flag vector to the LED stage
//   ev_count   saturating count of flagged results
module fp_flag_latch #(
    parameter int unsigned STRETCH_CYCLES = 25_000_000,
    parameter int unsigned DEB_CYCLES     = 500_000,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flag_valid,
    input  logic [3:0]       flag_in,
    input  logic             sticky_en,
    input  logic             clr_btn,
    output logic [3:0]       overfloat,
    output logic [CNT_W-1:0] ev_count
);

    localparam int unsigned TimerW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam int unsigned DebW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [TimerW-1:0] TimerLoad = TimerW'(STRETCH_CYCLES - 1);
    localparam logic [DebW-1:0]   DebLast   = DebW'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CntMax    = '1;

    typedef enum logic [1:0] {
        StIdle,
        StShow,
        StHold
    } state_e;

    // Clear button: synchronizer, debouncer, rising-edge pulse.
    logic            sync1_q, sync2_q;
    logic            deb_d, deb_q;
    logic [DebW-1:0] deb_cnt_d, deb_cnt_q;
    logic            clr_pulse_d, clr_pulse_q;

    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        // The count only runs while the input disagrees; any agreement restarts it.
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DebLast) begin
                deb_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DebW'(1);
            end
        end
    end

    assign clr_pulse_d = deb_d & ~deb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_q       <= 1'b0;
            deb_cnt_q   <= '0;
            clr_pulse_q <= 1'b0;
        end else begin
            sync1_q     <= clr_btn;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_cnt_q   <= deb_cnt_d;
            clr_pulse_q <= clr_pulse_d;
        end
    end

    // Display FSM and event counter.
    state_e            state_d, state_q;
    logic [3:0]        flags_d, flags_q;
    logic [TimerW-1:0] timer_d, timer_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              event_hit;

    assign event_hit = flag_valid && (flag_in != 4'b0000);

    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;

        if (clr_pulse_q) begin
            // Clear beats a simultaneous event; that event is dropped entirely.
            state_d = StIdle;
            flags_d = 4'b0000;
            timer_d = '0;
            cnt_d   = '0;
        end else begin
            if (event_hit && (cnt_q != CntMax)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            case (state_q)
                StIdle: begin
                    flags_d = 4'b0000;
                    if (event_hit) begin
                        flags_d = flag_in;
                        timer_d = TimerLoad;
                        state_d = sticky_en ? StHold : StShow;
                    end
                end
                StShow: begin
                    if (event_hit) begin
                        flags_d = flags_q | flag_in;
                        timer_d = TimerLoad;
                    end else if (sticky_en) begin
                        state_d = StHold;
                    end else if (timer_q == '0) begin
                        state_d = StIdle;
                        flags_d = 4'b0000;
                    end else begin
                        timer_d = timer_q - TimerW'(1);
                    end
                end
                StHold: begin
                    // Only the clear button releases held flags.
                    if (event_hit) begin
                        flags_d = flags_q | flag_in;
                    end
                end
                default: begin
                    state_d = StIdle;
                    flags_d = 4'b0000;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            flags_q <= 4'b0000;
            timer_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
        end
    end

    assign overfloat = flags_q;
    assign ev_count  = cnt_q;

endmodule

// File: tb/tb_fp_flag_latch.sv
// Scoreboard bench for fp_flag_latch. The stimulus process drives one cycle at
// a time and pushes the reference model's expected outputs into a queue. A
// monitor pops the queue and compares against the DUT on each falling edge.
module tb_fp_flag_latch;

    localparam int unsigned S   = 4;
    localparam int unsigned DEB = 3;
    localparam int unsigned CW  = 3;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flag_valid = 1'b0;
    logic [3:0]    flag_in = 4'b0000;
    logic          sticky_en = 1'b0;
    logic          clr_btn = 1'b0;
    logic [3:0]    overfloat;
    logic [CW-1:0] ev_count;

    fp_flag_latch #(
        .STRETCH_CYCLES(S),
        .DEB_CYCLES    (DEB),
        .CNT_W         (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flag_valid(flag_valid),
        .flag_in   (flag_in),
        .sticky_en (sticky_en),
        .clr_btn   (clr_btn),
        .overfloat (overfloat),
        .ev_count  (ev_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          tag;
        logic [3:0]  ov;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: flags lit until an absolute deadline, or held if sticky.
    logic [3:0]  m_flags;
    bit          m_hold;
    int          m_end;
    int unsigned m_cnt;
    bit          m_deb;
    bit          m_clr_pend;
    int          cyc;
    bit          btn_hist[$];
    bit          samp[$];

    task automatic model_reset();
        m_flags    = 4'b0000;
        m_hold     = 1'b0;
        m_end      = 0;
        m_cnt      = 0;
        m_deb      = 1'b0;
        m_clr_pend = 1'b0;
        cyc        = 0;
        btn_hist.delete();
        btn_hist.push_back(1'b0);
        btn_hist.push_back(1'b0);
        samp.delete();
        exp_q.delete();
    endtask

    task automatic model_edge(bit fv, logic [3:0] fin, bit st, bit btn);
        bit   s, clr_now, all_diff;
        exp_t e;
        cyc++;
        clr_now    = m_clr_pend;
        m_clr_pend = 1'b0;
        // The debouncer sees the button value from two edges earlier.
        s = btn_hist.pop_front();
        btn_hist.push_back(btn);
        samp.push_back(s);
        if (samp.size() > DEB) void'(samp.pop_front());
        if (samp.size() == DEB) begin
            all_diff = 1'b1;
            foreach (samp[i]) if (samp[i] == m_deb) all_diff = 1'b0;
            if (all_diff) begin
                m_deb = ~m_deb;
                if (m_deb) m_clr_pend = 1'b1;
            end
        end
        if (clr_now) begin
            m_flags = 4'b0000;
            m_hold  = 1'b0;
            m_cnt   = 0;
        end else if (fv && fin != 4'b0000) begin
            if (m_flags == 4'b0000) m_hold = st;
            m_flags = m_flags | fin;
            m_end   = cyc + S;
            if (m_cnt < CMAX) m_cnt++;
        end else if (m_flags != 4'b0000 && !m_hold) begin
            if (st) m_hold = 1'b1;
            else if (cyc >= m_end) m_flags = 4'b0000;
        end
        e.tag = cyc;
        e.ov  = m_flags;
        e.cnt = m_cnt[CW-1:0];
        exp_q.push_back(e);
    endtask

    task automatic step(bit fv, logic [3:0] fin, bit st, bit btn);
        #1;
        flag_valid = fv;
        flag_in    = fin;
        sticky_en  = st;
        clr_btn    = btn;
        @(posedge clk);
        model_edge(fv, fin, st, btn);
    endtask

    task automatic check_now(string name, logic [7:0] act, logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flag_valid = 1'b0;
        flag_in = 4'b0000;
        sticky_en = 1'b0;
        clr_btn = 1'b0;
        #2;
        check_now("reset_state", {overfloat, 1'b0, ev_count}, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            if (overfloat !== mon_e.ov || ev_count !== mon_e.cnt) begin
                n_err++;
                $display("FAIL scoreboard cyc=%0d: overfloat=%b ev_count=%0d, expected %b / %0d",
                         mon_e.tag, overfloat, ev_count, mon_e.ov, mon_e.cnt);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          r_st, r_btn;
        logic [3:0]  r_fin;
        model_reset();

        // Single stretch event.
        do_reset();
        step(1, 4'b0001, 0, 0);
        repeat (6) step(0, 4'b0000, 0, 0);
        #2 check_now("single_count", {5'b0, ev_count}, 8'd1);

        // Overlapping stretch events.
        do_reset();
        step(1, 4'b0001, 0, 0);
        step(0, 4'b0000, 0, 0);
        step(1, 4'b0100, 0, 0);
        #2 check_now("merged_flags", {4'b0, overfloat}, 8'b0101);
        repeat (6) step(0, 4'b0000, 0, 0);
        #2 check_now("merged_count", {5'b0, ev_count}, 8'd2);

        // Sticky hold, then a clean button press.
        do_reset();
        step(1, 4'b0010, 1, 0);
        step(1, 4'b1000, 1, 0);
        repeat (50) step(0, 4'b0000, 1, 0);
        #2 check_now("sticky_held", {4'b0, overfloat}, 8'b1010);
        repeat (6) step(0, 4'b0000, 1, 1);
        repeat (8) step(0, 4'b0000, 1, 0);
        #2 check_now("sticky_cleared", {overfloat, 1'b0, ev_count}, 8'h00);

        // Bouncing button must not clear.
        do_reset();
        step(1, 4'b0011, 1, 0);
        for (int i = 0; i < 20; i++) step(0, 4'b0000, 1, ((i / 2) % 2) == 0);
        repeat (10) step(0, 4'b0000, 0, 0);
        #2 check_now("bounce_no_clear", {overfloat, 1'b0, ev_count}, {4'b0011, 4'd1});

        // Counter saturation and empty strobes.
        do_reset();
        for (int i = 0; i < 9; i++) step(1, 4'($urandom_range(1, 15)), 0, 0);
        #2 check_now("count_saturated", {5'b0, ev_count}, 8'd7);
        repeat (3) step(1, 4'b0000, 0, 0);
        #2 check_now("empty_strobe", {5'b0, ev_count}, 8'd7);
        repeat (6) step(0, 4'b0000, 0, 0);

        // Clear coincident with an event: the event is dropped.
        do_reset();
        step(1, 4'b0100, 1, 0);
        repeat (5) step(0, 4'b0000, 1, 1);
        step(1, 4'b0001, 1, 1);
        #2 check_now("clear_beats_event", {overfloat, 1'b0, ev_count}, 8'h00);
        repeat (8) step(0, 4'b0000, 1, 0);

        // Asynchronous reset during SHOW with the timer at 2.
        do_reset();
        step(1, 4'b0001, 0, 0);
        step(0, 4'b0000, 0, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_now("async_reset", {overfloat, 1'b0, ev_count}, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Randomized traffic against the model.
        r_st  = 1'b0;
        r_btn = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 31) == 0) r_st = ~r_st;
            if ($urandom_range(0, 5) == 0) r_btn = ~r_btn;
            r_fin = 4'($urandom);
            step(($urandom_range(0, 2) == 0), r_fin, r_st, r_btn);
        end
        step(0, 4'b0000, 0, 0);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_flag_latch.md
# fp_flag_latch

Captures the per-result exception flags produced by the floating-point calculator and turns them into a stable 4-bit `overfloat` vector for the LED display stage. Single-cycle flag pulses are stretched to a human-visible duration, or held sticky until the operator clears them. A debounced push-button clears the flags, and a saturating counter records how many flagged results have occurred. The block sits between the float ALU result-valid strobe and the LED driver.

## Interface
- `STRETCH_CYCLES`, default 25_000_000: display hold time per event in stretch mode, in clk cycles (≥1).
- `DEB_CYCLES`, default 500_000: cycles the synchronized button must be stable before its level is accepted (≥1).
- `CNT_W`, default 8: width of the event counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flag_valid`  in  1  one-cycle strobe: `flag_in` belongs to a completed float operation.
- `flag_in`  in  4  [3] invalid/NaN, [2] divide-by-zero, [1] underflow, [0] overflow.
- `sticky_en`  in  1  switch: 1 = sticky mode, 0 = stretch mode.
- `clr_btn`  in  1  raw, asynchronous, bouncing push-button; high = pressed.
- `overfloat`  out  4  registered flag vector to the LED stage; same bit order as `flag_in`.
- `ev_count`  out  CNT_W  saturating count of flagged results.

## Operation
- Event: `flag_valid=1` and `flag_in!=0`. `flag_valid=1` with `flag_in=0` is ignored and not counted.
- Clear path: 2-FF synchronizer, then a stability counter. The debounced level changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count. A 0→1 transition of the debounced level produces a one-cycle `clr_pulse`. Holding the button produces exactly one pulse.
- FSM states:
  - IDLE: `overfloat=0`. On an event: `overfloat<=flag_in`, `timer<=STRETCH_CYCLES-1`. Next state is HOLD if `sticky_en`, else SHOW.
  - SHOW: on an event, `overfloat<=overfloat|flag_in` and reload the timer. Otherwise, if `sticky_en=1`, go to HOLD and keep the flags. Otherwise, if `timer==0`, go to IDLE and set `overfloat<=0`. Otherwise decrement the timer.
  - HOLD: on an event, `overfloat<=overfloat|flag_in`. Leaves only on `clr_pulse`. Setting `sticky_en=0` here does not release the flags.
- `clr_pulse` in any state: go to IDLE, `overfloat<=0`, `ev_count<=0`, timer to 0.
- Clear and event in the same cycle: clear wins, and the event is dropped and not counted.
- `ev_count` increments by 1 per event and saturates at 2^CNT_W−1.

## Timing
- Reset values: `overfloat=0`, `ev_count=0`, state IDLE, timer 0, synchronizer, debounced level and stability counter all 0.
- Event to `overfloat` latency: 1 cycle. Flags are visible after the edge that samples `flag_valid`.
- Stretch mode with an isolated event at edge k: `overfloat` is nonzero from edge k to edge k+STRETCH_CYCLES, i.e. exactly STRETCH_CYCLES cycles. Each new event restarts the full window.
- Button press to `clr_pulse`: 2 sync cycles plus DEB_CYCLES, then the clear takes effect on the following edge.
- `rst` mid-operation forces all reset values immediately, asynchronously, regardless of state or the timer value.

## Test plan
Bench parameters: STRETCH_CYCLES=4, DEB_CYCLES=3, CNT_W=3.
- Reset, then one event `flag_in=4'b0001` with `sticky_en=0`: `overfloat=0001` for exactly 4 cycles then 0; `ev_count=1`.
- Stretch mode: event `0001`, then event `0100` two cycles later: `overfloat` reads 0001, then 0101. It stays 0101 for 4 cycles after the second event; `ev_count=2`.
- Sticky mode: events `0010` then `1000`: `overfloat=1010` held for 50 cycles. Stable `clr_btn=1` for 6 cycles: `overfloat=0` and `ev_count=0`, with exactly one clear.
- Bouncing `clr_btn` (toggling every 2 cycles for 20 cycles): no clear occurs and `overfloat` is unchanged.
- 9 events back-to-back: `ev_count` saturates at 7. `flag_valid=1` with `flag_in=0`: no change.
- Clear pulse coincident with event `0001`: `overfloat=0` and `ev_count=0`. Assert `rst` during SHOW with the timer at 2: all outputs go to 0 immediately.
